passgate_bus_arbiter: RTL and testbench
=======================================

# passgate_bus_arbiter

Round-robin arbiter that shares one tri-state net among N drivers, each coupling onto the net through its own `rnmos` pass switch. It drives the switch gate enables one-hot, so at most one switch conducts at any time. Each owner's tenure is bounded by a hold limit. It optionally inserts break-before-make dead cycles, during which every switch is open and the net floats to `z`. It sits between the requesting agents and the switch-level bus fabric.

## Interface
- `N`, default 4: number of requesters, 2..16.
- `MAXHOLD`, default 8: maximum consecutive grant cycles per tenure, 1..255.
- `DEAD`, default 2: dead cycles between tenures, 1..15. Only used with the `_EN` macro.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `req`  in  N: request per agent; level, held while the agent wants the net.
- `gate_en`  out  N: registered one-hot-or-zero gate drive to the `rnmos` switches.
- `grant_id`  out  clog2(N): index of the current owner; 0 when none.
- `busy`  out  1: high while any `gate_en` bit is high.
- `preempt`  out  1: one-cycle pulse when a tenure is ended by `MAXHOLD`.

## Operation
- States:
  - `IDLE`: no grant.
  - `GRANT`: one gate closed.
  - `DEAD`: all gates open, counting down. Exists only with the macro.
- Round-robin pointer `ptr`: the search for the next owner starts at `ptr` and wraps N-1→0. On each grant, `ptr` is set to the winner index + 1 (mod N).
- `IDLE` → `GRANT`:
  - Taken when any `req` bit is high.
  - The winner is the first set `req` bit at or after `ptr`.
  - The winner's `gate_en` bit is set and the hold counter is loaded with 1.
- In `GRANT`, the hold counter increments each cycle. The tenure ends when:
  - the owner's `req` is low, which is a release; or
  - the counter equals `MAXHOLD` and another `req` bit is high, which is a preemption and pulses `preempt`.
- If the counter reaches `MAXHOLD` with no competing request, the owner keeps the gate. The counter saturates and no `preempt` is issued.
- End of tenure, with the macro: go to `DEAD` with all `gate_en` low and the dead counter loaded with `DEAD`. When the dead counter reaches 0, arbitrate again: go to `GRANT` if any req is high, otherwise `IDLE`.
- End of tenure, without the macro: in the same edge, either go to `IDLE` or move `gate_en` directly to the next winner. The owner's own bit is excluded from that arbitration.
- Requests that drop during `DEAD` are not remembered. Arbitration uses `req` only at the decision edge.
- Invariant: `$countones(gate_en) <= 1` at every edge.
  - With the macro, a 1→0 transition of one bit and a 0→1 transition of another never occur in the same cycle.

## Timing
- Reset values: `gate_en`=0, `grant_id`=0, `busy`=0, `preempt`=0, `ptr`=0, state `IDLE`, both counters 0.
- Reset asserted mid-tenure opens every switch asynchronously; no dead phase is applied.
- Grant latency from `IDLE`: `req` high at edge k → `gate_en` high after edge k.
- Release latency: owner `req` low sampled at edge k → owner `gate_en` low after edge k.
- Handover gap with the macro: exactly `DEAD` cycles with `gate_en`=0. Without the macro: 0 cycles.
- Tenure length with competition: at most `MAXHOLD` cycles.
- `grant_id` and `busy` are registered and change on the same edge as `gate_en`.

## Configuration
- Macro: `PASSGATE_ARB_DEADTIME_EN`.
- Defined: the `DEAD` state and dead counter are present, giving break-before-make.
- Undefined: `DEAD` state, dead counter and parameter `DEAD` are unused. Handover is make-on-same-edge, still one-hot because `gate_en` is a single register.

## Structure
- Package `passgate_arb_pkg` holds:
  - the state enum `arb_state_t` (`IDLE`, `GRANT`, `DEAD`);
  - the localparam for the hold-counter width (8) and the dead-counter width (4).
- Sub-module `rr_pick`: combinational round-robin priority picker.
  - Inputs: `req`, `ptr`, exclude mask.
  - Outputs: `valid`, one-hot `win`, encoded `win_id`.
- The top level holds the FSM, the counters and the output registers.

## Test plan
- Reset, then `req`=4'b0000 for 5 cycles → `gate_en`=0, `busy`=0.
- Single requester: `req`=4'b0100 at edge 1 → `gate_en`=4'b0100 and `grant_id`=2 after edge 1. Drop `req` at edge 6 → `gate_en`=0 after edge 6. Switch output equals the driven source, and `z` afterwards.
- Two requesters 4'b0011, MAXHOLD=8, DEAD=2, macro on:
  - agent 0 owns for 8 cycles, then `preempt` pulses;
  - 2 cycles follow with `gate_en`=0 and the monitored net `z`;
  - agent 1 then owns.
- Same stimulus with the macro off → `gate_en` goes 4'b0001→4'b0010 on one edge. A one-hot checker never fires.
- All four requesting continuously → grant order 0,1,2,3,0. Each tenure lasts 8 cycles.
- Assert `rst_n` low mid-tenure (`gate_en`=4'b1000) → `gate_en`=0 immediately, without waiting for a clock edge. After release, `ptr`=0, so with all requesting the next grant is agent 0.

Source files
------------

// File: rtl/passgate_arb_pkg.sv
// Shared types and widths for the pass-gate bus arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package passgate_arb_pkg;

    // IDLE: no switch closed; GRANT: exactly one switch closed;
    // DEAD: all switches open while the net discharges between owners.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DEAD  = 2'd2
    } arb_state_t;

    localparam int HOLD_W = 8;  // hold counter, covers MAXHOLD up to 255
    localparam int DEAD_W = 4;  // dead counter, covers DEAD up to 15

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first candidate at or after ptr, wrapping N-1 -> 0.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; valid is low when no unmasked request is present.
//
// Ports:
//   req    - request vector
//   ptr    - index where the search starts
//   excl   - mask of agents that may not win this round
//   valid  - some unmasked request exists
//   win    - one-hot winner
//   win_id - encoded winner index (0 when !valid)
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    input  logic [N-1:0]         excl,
    output logic                 valid,
    output logic [N-1:0]         win,
    output logic [$clog2(N)-1:0] win_id
);
    localparam int ID_W = $clog2(N);

    logic [N-1:0] cand;

    assign cand = req & ~excl;

    always_comb begin
        int                idx;
        logic [ID_W-1:0]   sel;
        valid  = 1'b0;
        win    = '0;
        win_id = '0;
        idx    = 0;
        sel    = '0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            sel = ID_W'(idx);
            if (!valid && cand[sel]) begin
                valid    = 1'b1;
                win[sel] = 1'b1;
                win_id   = sel;
            end
        end
    end

endmodule

// File: rtl/passgate_bus_arbiter.sv
// Round-robin owner selection for a tri-state net shared through rnmos pass switches.
// Latency: grant and release take effect on the edge that samples req (registered gate_en).
// Backpressure: an owner keeps the net while it requests, until MAXHOLD cycles with a competitor waiting.
//
// Ports:
//   clk, rst_n - rising-edge clock, asynchronous active-low reset
//   req        - per-agent level request
//   gate_en    - one-hot-or-zero switch gate drive
//   grant_id   - current owner index (0 when idle)
//   busy       - some gate is closed
//   preempt    - one-cycle pulse when a tenure is cut by MAXHOLD
//
// Build option: define PASSGATE_ARB_DEADTIME_EN to insert DEAD all-open cycles
// between owners (break-before-make). Without it, ownership moves on a single edge.
module passgate_bus_arbiter #(
    parameter int N       = 4,
    parameter int MAXHOLD = 8,
    parameter int DEAD    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gate_en,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 busy,
    output logic                 preempt
);
    import passgate_arb_pkg::*;

    localparam int ID_W = $clog2(N);
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAXHOLD);

    if (N < 2 || N > 16 || MAXHOLD < 1 || MAXHOLD > 255 || DEAD < 1 || DEAD > 15) begin : g_param_check
        $error("passgate_bus_arbiter: parameter out of range");
    end

    arb_state_t        state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [N-1:0]      gate_q, gate_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              busy_q, busy_d;
    logic              preempt_q, preempt_d;
`ifdef PASSGATE_ARB_DEADTIME_EN
    localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD);
    logic [DEAD_W-1:0] dead_q, dead_d;
`endif

    logic              pick_vld;
    logic [N-1:0]      pick_win;
    logic [ID_W-1:0]   pick_id;
    logic [ID_W-1:0]   ptr_nxt;
    logic              owner_req;
    logic              rivals;
    logic              hold_full;

    // The current owner is masked out of the search, so during a direct
    // handover the net can only move to a different agent. Outside GRANT
    // gate_q is zero and nothing is masked.
    rr_pick #(.N(N)) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .excl   (gate_q),
        .valid  (pick_vld),
        .win    (pick_win),
        .win_id (pick_id)
    );

    assign ptr_nxt   = (pick_id == ID_W'(N - 1)) ? '0 : pick_id + 1'b1;
    assign owner_req = |(req & gate_q);
    assign rivals    = |(req & ~gate_q);
    assign hold_full = (hold_q == HOLD_LIM);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        gate_d    = gate_q;
        id_d      = id_q;
        busy_d    = busy_q;
        preempt_d = 1'b0;
`ifdef PASSGATE_ARB_DEADTIME_EN
        dead_d    = dead_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = GRANT;
                    gate_d  = pick_win;
                    id_d    = pick_id;
                    busy_d  = 1'b1;
                    hold_d  = HOLD_W'(1);
                    ptr_d   = ptr_nxt;
                end
            end
            GRANT: begin
                if (!owner_req || (hold_full && rivals)) begin
                    // A still-requesting owner here can only mean a MAXHOLD cut.
                    preempt_d = owner_req;
`ifdef PASSGATE_ARB_DEADTIME_EN
                    state_d = passgate_arb_pkg::DEAD;
                    gate_d  = '0;
                    id_d    = '0;
                    busy_d  = 1'b0;
                    hold_d  = '0;
                    dead_d  = DEAD_LOAD;
`else
                    if (pick_vld) begin
                        gate_d = pick_win;
                        id_d   = pick_id;
                        hold_d = HOLD_W'(1);
                        ptr_d  = ptr_nxt;
                    end else begin
                        state_d = IDLE;
                        gate_d  = '0;
                        id_d    = '0;
                        busy_d  = 1'b0;
                        hold_d  = '0;
                    end
`endif
                end else if (!hold_full) begin
                    // Saturates at MAXHOLD when uncontested; the owner keeps the net.
                    hold_d = hold_q + 1'b1;
                end
            end
`ifdef PASSGATE_ARB_DEADTIME_EN
            passgate_arb_pkg::DEAD: begin
                // Arbitrate on the edge where the counter runs out, so the
                // all-open gap lasts exactly DEAD cycles.
                if (dead_q <= DEAD_W'(1)) begin
                    dead_d = '0;
                    if (pick_vld) begin
                        state_d = GRANT;
                        gate_d  = pick_win;
                        id_d    = pick_id;
                        busy_d  = 1'b1;
                        hold_d  = HOLD_W'(1);
                        ptr_d   = ptr_nxt;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    dead_d = dead_q - 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                gate_d  = '0;
                id_d    = '0;
                busy_d  = 1'b0;
                hold_d  = '0;
            end
        endcase
    end

    // Reset opens every switch immediately; no dead phase is applied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            hold_q    <= '0;
            gate_q    <= '0;
            id_q      <= '0;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
`ifdef PASSGATE_ARB_DEADTIME_EN
            dead_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            gate_q    <= gate_d;
            id_q      <= id_d;
            busy_q    <= busy_d;
            preempt_q <= preempt_d;
`ifdef PASSGATE_ARB_DEADTIME_EN
            dead_q    <= dead_d;
`endif
        end
    end

    assign gate_en  = gate_q;
    assign grant_id = id_q;
    assign busy     = busy_q;
    assign preempt  = preempt_q;

endmodule

// File: tb/tb_passgate_bus_arbiter.sv
// Self-checking bench for passgate_bus_arbiter with a tenure-level reference model.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_passgate_bus_arbiter;

    localparam int N       = 4;
    localparam int MAXHOLD = 8;
    localparam int DEAD    = 2;
`ifdef PASSGATE_ARB_DEADTIME_EN
    localparam bit DT_EN = 1'b1;
`else
    localparam bit DT_EN = 1'b0;
`endif
    localparam int EXP_GAP = DT_EN ? DEAD : 0;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic [N-1:0] req   = '0;
    logic [N-1:0] gate_en;
    logic [1:0]   grant_id;
    logic         busy;
    logic         preempt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    passgate_bus_arbiter #(.N(N), .MAXHOLD(MAXHOLD), .DEAD(DEAD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .gate_en  (gate_en),
        .grant_id (grant_id),
        .busy     (busy),
        .preempt  (preempt)
    );

    // Shared net seen through the switches: each agent drives 8'hA0|i.
    // net_drv low means every switch is open and the net floats (z).
    logic       net_drv;
    logic [7:0] net_val;
    always_comb begin
        net_drv = 1'b0;
        net_val = 8'h00;
        for (int i = 0; i < N; i++) begin
            if (gate_en[i]) begin
                net_drv = 1'b1;
                net_val = net_val | (8'hA0 | 8'(i));
            end
        end
    end

    // Reference model: owner (-1 none), cycles held, remaining gap, rr pointer.
    int m_owner = -1;
    int m_held  = 0;
    int m_gap   = 0;
    int m_rr    = 0;
    bit m_pre   = 1'b0;

    function automatic void m_reset();
        m_owner = -1;
        m_held  = 0;
        m_gap   = 0;
        m_rr    = 0;
        m_pre   = 1'b0;
    endfunction

    function automatic void m_choose(logic [N-1:0] r, int excl);
        m_owner = -1;
        for (int i = 0; i < N; i++) begin
            int c;
            logic [N-1:0] bm;
            c  = (m_rr + i) % N;
            bm = N'(1) << c;
            if ((r & bm) != '0 && c != excl) begin
                m_owner = c;
                m_rr    = (c + 1) % N;
                m_held  = 1;
                break;
            end
        end
    endfunction

    function automatic void m_end(logic [N-1:0] r);
        if (DT_EN) begin
            m_owner = -1;
            m_gap   = DEAD;
        end else begin
            m_choose(r, m_owner);
        end
    endfunction

    function automatic void m_step(logic [N-1:0] r);
        m_pre = 1'b0;
        if (m_gap > 0) begin
            m_gap--;
            if (m_gap == 0) m_choose(r, -1);
        end else if (m_owner < 0) begin
            m_choose(r, -1);
        end else begin
            logic [N-1:0] own_m;
            own_m = N'(1) << m_owner;
            if ((r & own_m) == '0) begin
                m_end(r);
            end else if (m_held >= MAXHOLD && (r & ~own_m) != '0) begin
                m_pre = 1'b1;
                m_end(r);
            end else begin
                m_held++;
            end
        end
    endfunction

    function automatic logic [N-1:0] exp_gate();
        return (m_owner < 0) ? '0 : (N'(1) << m_owner);
    endfunction

    function automatic logic [1:0] exp_id();
        return (m_owner < 0) ? 2'd0 : 2'(m_owner);
    endfunction

    // Advance one edge: the model consumes the req the DUT sampled, and
    // outputs are observed 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        m_step(req);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if (gate_en !== '0 || grant_id !== 2'd0 || busy !== 1'b0 || preempt !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: gate_en=%b grant_id=%0d busy=%b preempt=%b, required all 0",
                     gate_en, grant_id, busy, preempt);
        end
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        req   = '0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (gate_en !== '0 || busy !== 1'b0 || net_drv !== 1'b0) begin
                failures++;
                $display("FAIL idle_no_req cycle %0d: gate_en=%b busy=%b net_drv=%b, required 0/0/0",
                         c, gate_en, busy, net_drv);
            end
        end
    endtask

    task automatic test_single();
        req = 4'b0100;
        tick();
        checks++;
        if (gate_en !== 4'b0100 || grant_id !== 2'd2 || busy !== 1'b1 || net_val !== 8'hA2 || net_drv !== 1'b1) begin
            failures++;
            $display("FAIL single_grant: gate_en=%b id=%0d busy=%b net=%h drv=%b, required 0100/2/1/a2/1",
                     gate_en, grant_id, busy, net_val, net_drv);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (gate_en !== 4'b0100 || preempt !== 1'b0) begin
                failures++;
                $display("FAIL single_hold cycle %0d: gate_en=%b preempt=%b, required 0100/0", c, gate_en, preempt);
            end
        end
        req = '0;
        tick();
        checks++;
        if (gate_en !== '0 || busy !== 1'b0 || grant_id !== 2'd0 || net_drv !== 1'b0) begin
            failures++;
            $display("FAIL single_release: gate_en=%b busy=%b id=%0d net_drv=%b, required 0/0/0/floating",
                     gate_en, busy, grant_id, net_drv);
        end
    endtask

    task automatic test_preempt();
        int  own;
        int  gap;
        bit  gap_float;
        req = '0;
        repeat (4) tick();
        req = 4'b0011;
        tick();
        checks++;
        if (gate_en !== 4'b0001) begin
            failures++;
            $display("FAIL preempt_first_owner: gate_en=%b, required 0001", gate_en);
        end
        own = 1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (gate_en !== 4'b0001) break;
            own++;
        end
        checks++;
        if (own != MAXHOLD || preempt !== 1'b1) begin
            failures++;
            $display("FAIL preempt_tenure: held=%0d preempt=%b, required %0d/1", own, preempt, MAXHOLD);
        end
        gap       = 0;
        gap_float = 1'b1;
        while (gate_en === '0 && gap < 20) begin
            if (net_drv !== 1'b0) gap_float = 1'b0;
            gap++;
            tick();
        end
        checks++;
        if (gap != EXP_GAP || !gap_float) begin
            failures++;
            $display("FAIL handover_gap: gap=%0d floating=%b, required %0d/1", gap, gap_float, EXP_GAP);
        end
        checks++;
        if (gate_en !== 4'b0010 || grant_id !== 2'd1 || net_val !== 8'hA1) begin
            failures++;
            $display("FAIL preempt_next_owner: gate_en=%b id=%0d net=%h, required 0010/1/a1",
                     gate_en, grant_id, net_val);
        end
    endtask

    task automatic test_round_robin();
        int           order[$];
        int           lens[$];
        int           len;
        logic [N-1:0] prev;
        int           exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};
        req  = 4'b1111;
        apply_reset();
        len  = 0;
        prev = '0;
        for (int c = 0; c < 200 && order.size() < 5; c++) begin
            tick();
            if (gate_en !== '0 && gate_en !== prev) begin
                if (order.size() > 0) lens.push_back(len);
                order.push_back(int'(grant_id));
                len = 1;
            end else if (gate_en !== '0) begin
                len++;
            end
            prev = gate_en;
        end
        checks++;
        if (order.size() != 5) begin
            failures++;
            $display("FAIL rr_timeout: grants seen=%0d, required 5", order.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (order[i] != exp_order[i]) begin
                    failures++;
                    $display("FAIL rr_order[%0d]: owner=%0d, required %0d", i, order[i], exp_order[i]);
                end
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (lens[i] != MAXHOLD) begin
                    failures++;
                    $display("FAIL rr_tenure[%0d]: length=%0d, required %0d", i, lens[i], MAXHOLD);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int waited;
        req    = 4'b1111;
        waited = 0;
        while (gate_en !== 4'b1000 && waited < 100) begin
            tick();
            waited++;
        end
        checks++;
        if (gate_en !== 4'b1000) begin
            failures++;
            $display("FAIL reset_mid_setup: gate_en=%b, required 1000", gate_en);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (gate_en !== '0 || busy !== 1'b0 || grant_id !== 2'd0 || net_drv !== 1'b0) begin
            failures++;
            $display("FAIL reset_async: gate_en=%b busy=%b id=%0d net_drv=%b, required 0/0/0/floating",
                     gate_en, busy, grant_id, net_drv);
        end
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (gate_en !== 4'b0001 || grant_id !== 2'd0) begin
            failures++;
            $display("FAIL reset_ptr: gate_en=%b id=%0d, required 0001/0", gate_en, grant_id);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] prev;
        prev = gate_en;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(3) == 0) req = N'($urandom_range(15));
            tick();
            checks++;
            if (gate_en !== exp_gate() || grant_id !== exp_id() || busy !== (m_owner >= 0) ||
                preempt !== m_pre) begin
                failures++;
                $display("FAIL random_model cycle %0d: gate_en=%b id=%0d busy=%b pre=%b, required %b/%0d/%b/%b",
                         c, gate_en, grant_id, busy, preempt, exp_gate(), exp_id(), (m_owner >= 0), m_pre);
            end
            checks++;
            if (net_drv !== (m_owner >= 0) || (m_owner >= 0 && net_val !== (8'hA0 | 8'(m_owner)))) begin
                failures++;
                $display("FAIL random_net cycle %0d: drv=%b val=%h, required owner %0d", c, net_drv, net_val, m_owner);
            end
            checks++;
            if ($countones(gate_en) > 1 ||
                (DT_EN && (prev & ~gate_en) != '0 && (gate_en & ~prev) != '0)) begin
                failures++;
                $display("FAIL one_hot cycle %0d: prev=%b now=%b, required one-hot and break-before-make=%b",
                         c, prev, gate_en, DT_EN);
            end
            prev = gate_en;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_preempt();
        test_round_robin();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
